// File: rtl/inst_fetch_seq.sv
// Instruction-fetch sequencer: owns the fetch PC, drives the combinational ROM and
// buffers fetched words in a small FIFO. Optional self-loop halt: INST_FETCH_HALT_EN.
module inst_fetch_seq #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clrn,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        halted
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {FETCH, HALT} state_t;

  state_t          state_reg, state_next;
  logic [31:0]     fetch_pc_reg;
  logic [PW-1:0]   head_reg, tail_reg;
  logic [CW-1:0]   count_reg;
  logic [31:0]     last_pc_reg, last_inst_reg;
  logic [31:0]     q_pc   [DEPTH];
  logic [31:0]     q_inst [DEPTH];
  logic [31:0]     pc4;
  logic            pop, push, self_loop;
  logic            unused_redirect_lsbs;

  assign unused_redirect_lsbs = &{1'b0, redirect_pc[1:0]};

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign pc4       = fetch_pc_reg + 32'd4;
  assign rom_addr  = fetch_pc_reg;
  assign out_valid = (count_reg != '0);
  assign pop       = out_valid & out_ready;
  assign push      = (state_reg == FETCH) & ~redirect & ((count_reg < CW'(DEPTH)) | pop);

  // When empty, present the last word handed to decode so out_* never glitch.
  assign out_pc   = out_valid ? q_pc[head_reg]   : last_pc_reg;
  assign out_inst = out_valid ? q_inst[head_reg] : last_inst_reg;

`ifdef INST_FETCH_HALT_EN
  // A J whose target is its own address would refetch forever; stop after one copy.
  assign self_loop = (rom_inst[31:26] == 6'b000010) &&
                     ({pc4[31:28], rom_inst[25:0], 2'b00} == fetch_pc_reg);
  assign halted    = (state_reg == HALT);
`else
  assign self_loop = 1'b0;
  assign halted    = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    if (redirect) begin
      state_next = FETCH;
    end else if (push && self_loop) begin
      state_next = HALT;
    end
  end

  // Queue storage needs no reset: count gates every read of it.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push && (tail_reg == PW'(gi))) begin
        q_pc[gi]   <= fetch_pc_reg;
        q_inst[gi] <= rom_inst;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_reg     <= FETCH;
      fetch_pc_reg  <= RESET_PC;
      head_reg      <= '0;
      tail_reg      <= '0;
      count_reg     <= '0;
      last_pc_reg   <= '0;
      last_inst_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (pop && !redirect) begin
        last_pc_reg   <= q_pc[head_reg];
        last_inst_reg <= q_inst[head_reg];
      end
      if (redirect) begin
        fetch_pc_reg <= {redirect_pc[31:2], 2'b00};
        head_reg     <= '0;
        tail_reg     <= '0;
        count_reg    <= '0;
      end else begin
        if (push) begin
          fetch_pc_reg <= pc4;
          tail_reg     <= ptr_inc(tail_reg);
        end
        if (pop) begin
          head_reg <= ptr_inc(head_reg);
        end
        if (push && !pop) begin
          count_reg <= count_reg + CW'(1);
        end else if (pop && !push) begin
          count_reg <= count_reg - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_seq.sv
// Directed bench for inst_fetch_seq: table of per-cycle vectors plus hand sequences
// for redirect-to-self-loop and asynchronous mid-stream reset.
module tb_inst_fetch_seq;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        halted;

  int checks = 0;
  int errors = 0;

  logic [31:0] rom [32];
  assign rom_inst = rom[rom_addr[6:2]];

  inst_fetch_seq #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .clrn(clrn), .rom_addr(rom_addr), .rom_inst(rom_inst),
    .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        do_rst;
    logic        rdy;
    logic        rdr;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
  } vec_t;

  vec_t tv [17];

  function automatic vec_t mk(input logic do_rst, input logic rdy, input logic rdr,
                              input logic [31:0] rpc, input logic ev,
                              input logic [31:0] epc, input logic [31:0] eaddr);
    vec_t v;
    v.do_rst = do_rst; v.rdy = rdy; v.rdr = rdr; v.rpc = rpc;
    v.ev = ev; v.epc = epc; v.eaddr = eaddr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Entered at posedge+1; leaves at the next posedge+1.
  task automatic do_reset();
    clrn = 1'b0; redirect = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_addr", rom_addr, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_inst", out_inst, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    $display("reset: valid=%0b addr=%h pc=%h inst=%h", out_valid, rom_addr, out_pc, out_inst);
    @(posedge clk); #1;
    clrn = 1'b1;
  endtask

  task automatic step(input string tag, input logic rdy, input logic rdr, input logic [31:0] rpc,
                      input logic ev, input logic [31:0] epc, input logic [31:0] eaddr,
                      input logic ehalt);
    logic [31:0] einst;
    out_ready = rdy; redirect = rdr; redirect_pc = rpc;
    @(negedge clk);
    $display("%s: rdy=%0b rdr=%0b valid=%0b pc=%h inst=%h addr=%h halted=%0b",
             tag, rdy, rdr, out_valid, out_pc, out_inst, rom_addr, halted);
    chk({tag, "_valid"}, {31'b0, out_valid}, {31'b0, ev});
    chk({tag, "_addr"}, rom_addr, eaddr);
    chk({tag, "_halted"}, {31'b0, halted}, {31'b0, ehalt});
    if (ev) begin
      einst = rom[epc[6:2]];
      chk({tag, "_pc"}, out_pc, epc);
      chk({tag, "_inst"}, out_inst, einst);
    end
    @(posedge clk); #1;
    redirect = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 32'h2000_0000 | (i << 16) | i;
    rom[0]    = 32'h3c01_0000;
    rom[1]    = 32'h3424_0050;
    rom[5'h17] = 32'h0800_0017;
    rom[5'h18] = 32'h8c43_0018;

    // Streaming from reset
    tv[0]  = mk(1, 1, 0, 0, 0, 0,            32'h0);
    tv[1]  = mk(0, 1, 0, 0, 1, 32'h0,        32'h4);
    tv[2]  = mk(0, 1, 0, 0, 1, 32'h4,        32'h8);
    // Back-pressure from reset, then drain
    tv[3]  = mk(1, 0, 0, 0, 0, 0,            32'h0);
    tv[4]  = mk(0, 0, 0, 0, 1, 32'h0,        32'h4);
    tv[5]  = mk(0, 0, 0, 0, 1, 32'h0,        32'h8);
    tv[6]  = mk(0, 0, 0, 0, 1, 32'h0,        32'h8);
    tv[7]  = mk(0, 1, 0, 0, 1, 32'h0,        32'h8);
    tv[8]  = mk(0, 1, 0, 0, 1, 32'h4,        32'hC);
    tv[9]  = mk(0, 0, 0, 0, 1, 32'h8,        32'h10);
    // Redirect while full, misaligned target
    tv[10] = mk(0, 1, 1, 32'h62, 1, 32'h8,   32'h10);
    tv[11] = mk(0, 1, 0, 0, 0, 0,            32'h60);
    tv[12] = mk(0, 1, 0, 0, 1, 32'h60,       32'h64);
    // Redirect to top of address space, wrap
    tv[13] = mk(0, 1, 1, 32'hFFFF_FFFC, 1, 32'h64, 32'h68);
    tv[14] = mk(0, 1, 0, 0, 0, 0,            32'hFFFF_FFFC);
    tv[15] = mk(0, 1, 0, 0, 1, 32'hFFFF_FFFC, 32'h0);
    tv[16] = mk(0, 1, 0, 0, 1, 32'h0,        32'h4);

    @(posedge clk); #1;
    for (int i = 0; i < 17; i++) begin
      if (tv[i].do_rst) do_reset();
      step($sformatf("vec%0d", i), tv[i].rdy, tv[i].rdr, tv[i].rpc,
           tv[i].ev, tv[i].epc, tv[i].eaddr, 1'b0);
    end

    // Redirect onto the self-loop J at 0x5C
    step("loop_rdr", 1, 1, 32'h5C, 1, 32'h4, 32'h8, 0);
    step("loop_a", 1, 0, 0, 0, 0, 32'h5C, 0);
`ifdef INST_FETCH_HALT_EN
    step("loop_b", 1, 0, 0, 1, 32'h5C, 32'h60, 1);
    step("loop_c", 1, 0, 0, 0, 0, 32'h60, 1);
    step("loop_d", 1, 0, 0, 0, 0, 32'h60, 1);
    step("loop_e", 1, 1, 32'h0, 0, 0, 32'h60, 1);
    step("loop_f", 1, 0, 0, 0, 0, 32'h0, 0);
    step("loop_g", 1, 0, 0, 1, 32'h0, 32'h4, 0);
`else
    step("loop_b", 1, 0, 0, 1, 32'h5C, 32'h60, 0);
    step("loop_c", 1, 0, 0, 1, 32'h60, 32'h64, 0);
    step("loop_d", 1, 1, 32'h0, 1, 32'h64, 32'h68, 0);
    step("loop_e", 1, 0, 0, 0, 0, 32'h0, 0);
    step("loop_f", 1, 0, 0, 1, 32'h0, 32'h4, 0);
`endif

    // Asynchronous reset with two entries queued
    do_reset();
    step("ar_a", 0, 0, 0, 0, 0, 32'h0, 0);
    step("ar_b", 0, 0, 0, 1, 32'h0, 32'h4, 0);
    @(negedge clk);
    chk("ar_full_valid", {31'b0, out_valid}, 32'h1);
    chk("ar_full_addr", rom_addr, 32'h8);
    #1 clrn = 1'b0;
    #1;
    $display("async_rst: valid=%0b addr=%h pc=%h", out_valid, rom_addr, out_pc);
    chk("ar_valid", {31'b0, out_valid}, 32'h0);
    chk("ar_addr", rom_addr, 32'h0);
    chk("ar_pc", out_pc, 32'h0);
    @(posedge clk); #1;
    clrn = 1'b1;
    step("ar_c", 1, 0, 0, 0, 0, 32'h0, 0);
    step("ar_d", 1, 0, 0, 1, 32'h0, 32'h4, 0);
    step("ar_e", 1, 0, 0, 1, 32'h4, 32'h8, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
